// File: rtl/vend_arbiter.sv
// Two-port round-robin coin arbiter locking the shared vending core to one requester per transaction.
// Optional inactivity timeout/refund path is enabled by defining VEND_ARB_TIMEOUT_EN.
module vend_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] coin0,
  input  logic [1:0] coin1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [1:0] vm_in,
  output logic       vm_rst,
  input  logic       vm_out,
  input  logic [1:0] vm_change,
  output logic       vend0,
  output logic       vend1,
  output logic [1:0] chg0,
  output logic [1:0] chg1,
  output logic       refund0,
  output logic       refund1,
  output logic [2:0] refund_amt,
  output logic       busy,
  output logic       owner
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN0  = 2'd1;
  localparam logic [1:0] OWN1  = 2'd2;
  localparam logic [1:0] ABORT = 2'd3;

  logic [1:0]      state;
  logic [1:0]      req, elig, gnt_q, vend_q;
  logic [1:0][1:0] coin, chg_q;
  logic [1:0]      win_coin, own_coin;
  logic            rr, win;
  logic [2:0]      credit;
  logic [3:0]      csum;

  assign req  = {req1, req0};
  assign coin = {coin1, coin0};

  // A requester still seeing its own grant is holding the coin we just took.
  assign elig     = req & ~gnt_q;
  assign win      = (elig == 2'b11) ? rr : elig[1];
  assign win_coin = coin[win];
  assign own_coin = coin[owner];
  assign csum     = {1'b0, credit} + {2'b00, own_coin};

  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign vend0 = vend_q[0];
  assign vend1 = vend_q[1];
  assign chg0  = chg_q[0];
  assign chg1  = chg_q[1];

`ifdef VEND_ARB_TIMEOUT_EN
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);
  logic [TW-1:0] timer;
  logic [1:0]    refund_q;
  logic [2:0]    refund_amt_q;
  assign refund0    = refund_q[0];
  assign refund1    = refund_q[1];
  assign refund_amt = refund_amt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, TW};
  assign refund0    = 1'b0;
  assign refund1    = 1'b0;
  assign refund_amt = 3'd0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      rr     <= 1'b0;
      credit <= 3'd0;
      owner  <= 1'b0;
      busy   <= 1'b0;
      gnt_q  <= 2'b00;
      vm_in  <= 2'b00;
      vm_rst <= 1'b1;
      vend_q <= 2'b00;
      chg_q  <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
      timer        <= '0;
      refund_q     <= 2'b00;
      refund_amt_q <= 3'd0;
`endif
    end else begin
      gnt_q  <= 2'b00;
      vm_in  <= 2'b00;
      vm_rst <= 1'b0;
      vend_q <= 2'b00;
      chg_q  <= '0;
`ifdef VEND_ARB_TIMEOUT_EN
      refund_q     <= 2'b00;
      refund_amt_q <= 3'd0;
`endif
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (|elig) begin
            gnt_q[win] <= 1'b1;
            // 00/11 are swallowed without opening a transaction
            if (^win_coin) begin
              vm_in  <= win_coin;
              credit <= {1'b0, win_coin};
              owner  <= win;
              busy   <= 1'b1;
              state  <= win ? OWN1 : OWN0;
`ifdef VEND_ARB_TIMEOUT_EN
              timer  <= '0;
`endif
            end
          end
        end
        OWN0, OWN1: begin
          // vend beats timeout beats coin acceptance
          if (vm_out) begin
            vend_q[owner] <= 1'b1;
            chg_q[owner]  <= vm_change;
            credit        <= 3'd0;
            rr            <= ~owner;
            state         <= IDLE;
`ifdef VEND_ARB_TIMEOUT_EN
          end else if (timer == TMO) begin
            refund_q[owner] <= 1'b1;
            refund_amt_q    <= credit;
            vm_rst          <= 1'b1;
            state           <= ABORT;
`endif
          end else begin
`ifdef VEND_ARB_TIMEOUT_EN
            timer <= timer + TW'(1);
`endif
            if (elig[owner]) begin
              gnt_q[owner] <= 1'b1;
              if (^own_coin) begin
                vm_in  <= own_coin;
                credit <= csum[3] ? 3'd7 : csum[2:0];
`ifdef VEND_ARB_TIMEOUT_EN
                timer  <= '0;
`endif
              end
            end
          end
        end
`ifdef VEND_ARB_TIMEOUT_EN
        ABORT: begin
          credit <= 3'd0;
          rr     <= ~owner;
          busy   <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vend_arbiter.sv
// Directed self-checking bench for vend_arbiter; timeout scenarios follow VEND_ARB_TIMEOUT_EN.
module tb_vend_arbiter;
  logic       clk = 1'b0, rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, vm_out = 1'b0;
  logic [1:0] coin0 = 2'b00, coin1 = 2'b00, vm_change = 2'b00;
  logic       gnt0, gnt1, vm_rst, vend0, vend1, refund0, refund1, busy, owner;
  logic [1:0] vm_in, chg0, chg1;
  logic [2:0] refund_amt;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  vend_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .coin0(coin0), .coin1(coin1),
    .gnt0(gnt0), .gnt1(gnt1), .vm_in(vm_in), .vm_rst(vm_rst), .vm_out(vm_out),
    .vm_change(vm_change), .vend0(vend0), .vend1(vend1), .chg0(chg0), .chg1(chg1),
    .refund0(refund0), .refund1(refund1), .refund_amt(refund_amt), .busy(busy), .owner(owner)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    tick(2);
    chk("rst_vm_rst", 32'(vm_rst), 1);
    chk("rst_outs", 32'({gnt1, gnt0, vm_in, vend1, vend0, chg1, chg0, refund1, refund0, refund_amt, busy, owner}), 0);
    rst = 1'b1; tick();
    chk("rel_vm_rst", 32'({vm_rst, busy}), 0);

    // single transaction: Rs2 then Rs1, core vends with change 01
    req0 = 1'b1; coin0 = 2'b10; tick();
    chk("t1_gnt_a", 32'({gnt1, gnt0, vm_in}), 32'b0110);
    chk("t1_busy_a", 32'({busy, owner}), 32'b10);
    req0 = 1'b0; coin0 = 2'b00; tick();
    chk("t1_gap", 32'({gnt0, vm_in}), 0);
    req0 = 1'b1; coin0 = 2'b01; tick();
    chk("t1_gnt_b", 32'({gnt0, vm_in}), 32'b101);
    req0 = 1'b0; coin0 = 2'b00; vm_out = 1'b1; vm_change = 2'b01; tick();
    chk("t1_vend", 32'({vend1, vend0, chg0, busy, vm_in}), 32'b0101100);
    vm_out = 1'b0; vm_change = 2'b00; tick();
    chk("t1_idle", 32'({vend0, busy}), 0);

    // reset mid-OWN0 with credit 2: silent drop, core held in reset
    req0 = 1'b1; coin0 = 2'b10; tick();
    req0 = 1'b0; coin0 = 2'b00;
    chk("r2_own", 32'({busy, owner}), 32'b10);
    tick();
    rst = 1'b0; #1;
    chk("r2_vm_rst", 32'(vm_rst), 1);
    chk("r2_outs", 32'({gnt1, gnt0, vm_in, vend1, vend0, chg1, chg0, refund1, refund0, refund_amt, busy, owner}), 0);
    tick();
    rst = 1'b1; tick();
    chk("r2_rel", 32'({vm_rst, busy, gnt0, gnt1}), 0);

    // contention from reset: port 0 first, port 1 blocked until vend, then rr favours port 1
    req0 = 1'b1; coin0 = 2'b01; req1 = 1'b1; coin1 = 2'b01; tick();
    chk("c_first", 32'({gnt1, gnt0, owner, vm_in}), 32'b01001);
    req0 = 1'b0; coin0 = 2'b00; tick(3);
    chk("c_blocked", 32'({gnt1, busy, owner}), 32'b010);
    vm_out = 1'b1; tick();
    chk("c_vend0", 32'({vend0, gnt1}), 32'b10);
    vm_out = 1'b0; req0 = 1'b1; coin0 = 2'b01; tick();
    chk("c_rr", 32'({gnt1, gnt0, owner, busy}), 32'b1011);
    req1 = 1'b0; coin1 = 2'b00; tick();
    chk("c_blk0", 32'(gnt0), 0);
    req0 = 1'b0; coin0 = 2'b00; vm_out = 1'b1; vm_change = 2'b10; tick();
    chk("c_vend1", 32'({vend1, vend0, chg1}), 32'b1010);
    vm_out = 1'b0; vm_change = 2'b00; tick();
    chk("c_idle", 32'(busy), 0);

    // illegal and empty coins in IDLE: granted, nothing forwarded
    req0 = 1'b1; coin0 = 2'b11; tick();
    chk("ill_idle", 32'({gnt0, vm_in, busy}), 32'b1000);
    req0 = 1'b0; coin0 = 2'b00; tick();
    req1 = 1'b1; coin1 = 2'b00; tick();
    chk("nil_idle", 32'({gnt1, vm_in, busy}), 32'b1000);
    req1 = 1'b0; tick();

`ifdef VEND_ARB_TIMEOUT_EN
    // timeout: Rs2 on port 1, abort 16 edges later, port 0 granted after ABORT
    req1 = 1'b1; coin1 = 2'b10; tick();
    chk("to_acc", 32'({gnt1, owner}), 32'b11);
    req1 = 1'b0; coin1 = 2'b00; tick(15);
    chk("to_early", 32'({refund1, vm_rst}), 0);
    req0 = 1'b1; coin0 = 2'b01; tick();
    chk("to_abort", 32'({refund1, refund0, refund_amt, vm_rst, busy, gnt0}), 32'b10010110);
    tick();
    chk("to_after", 32'({refund1, vm_rst, busy, gnt0}), 0);
    tick();
    chk("to_next", 32'({gnt0, owner, busy}), 32'b101);
    req0 = 1'b0; coin0 = 2'b00; tick();
    // illegal coin in OWN0 must neither clear the timer nor add credit
    req0 = 1'b1; coin0 = 2'b11; tick();
    chk("ill_own", 32'({gnt0, vm_in}), 32'b100);
    req0 = 1'b0; coin0 = 2'b00; tick(13);
    chk("ill_early", 32'(refund0), 0);
    tick();
    chk("ill_tmr", 32'({refund0, refund_amt}), 32'b1001);
    tick();

    // four Rs2 coins saturate credit at 7
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; coin0 = 2'b10; tick();
      req0 = 1'b0; coin0 = 2'b00; tick();
    end
    tick(14);
    chk("sat_early", 32'(refund0), 0);
    tick();
    chk("sat_amt", 32'({refund0, refund_amt}), 32'b1111);
    tick();

    // collision: vend, timeout and a pending coin on the same edge
    req0 = 1'b1; coin0 = 2'b01; tick();
    req0 = 1'b0; coin0 = 2'b00; tick(15);
    vm_out = 1'b1; req0 = 1'b1; coin0 = 2'b01; tick();
    chk("col", 32'({vend0, refund0, gnt0, vm_rst, busy}), 32'b10001);
    vm_out = 1'b0; req0 = 1'b0; coin0 = 2'b00; tick();
    chk("col_after", 32'({refund0, busy}), 0);
`else
    // no timeout: lock held indefinitely, refund outputs stay low
    req1 = 1'b1; coin1 = 2'b10; tick();
    req1 = 1'b0; coin1 = 2'b00; tick(30);
    chk("nt_held", 32'({busy, owner, refund1, vm_rst}), 32'b1100);
    req0 = 1'b1; coin0 = 2'b01; tick(2);
    chk("nt_blk0", 32'(gnt0), 0);
    vm_out = 1'b1; tick();
    chk("nt_vend1", 32'({vend1, gnt0, refund1}), 32'b100);
    vm_out = 1'b0; tick();
    chk("nt_next", 32'({gnt0, owner, busy}), 32'b101);
    req0 = 1'b0; coin0 = 2'b00; tick();
    req0 = 1'b1; coin0 = 2'b11; tick();
    chk("ill_own", 32'({gnt0, vm_in}), 32'b100);
    req0 = 1'b0; coin0 = 2'b00; tick();
    vm_out = 1'b1; req0 = 1'b1; coin0 = 2'b01; tick();
    chk("col", 32'({vend0, gnt0, refund0}), 32'b100);
    vm_out = 1'b0; req0 = 1'b0; coin0 = 2'b00; tick();
    chk("col_after", 32'(busy), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vend_arbiter.md
# vend_arbiter

Two-port coin arbiter and transaction scheduler in front of the single `vending_machine` core. Two coin entry points share the core's `in` port. A round-robin arbiter grants the shared core to one requester at a time and locks it to that requester until a vend completes or an inactivity timeout aborts the transaction. The core's `out` and `change` results are routed back to the owning requester, and aborted transactions are refunded.

## Interface

**Parameters**
- `TIMEOUT`, default 15: idle cycles in a locked transaction before it is aborted. Range 1..15.
- `TW`, default 4: timeout counter width. Must satisfy 2^TW > TIMEOUT.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `req0`, `req1` in 1: requester k presents a coin. Held until `gntk` is seen.
- `coin0`, `coin1` in 2: coin value: 00 none, 01 Rs1, 10 Rs2, 11 illegal.
- `gnt0`, `gnt1` out 1: one-cycle pulse meaning the coin was consumed.
- `vm_in` out 2: drives core `in`.
- `vm_rst` out 1: drives core `rst` (active-high).
- `vm_out` in 1: core vend pulse.
- `vm_change` in 2: core change, valid with `vm_out`.
- `vend0`, `vend1` out 1: routed vend pulse.
- `chg0`, `chg1` out 2: routed change, valid with `vendk`.
- `refund0`, `refund1` out 1: abort/refund pulse.
- `refund_amt` out 3: refunded credit in Rs, valid with `refundk`.
- `busy` out 1: a transaction lock is held.
- `owner` out 1: owning requester, valid while `busy`.

## Operation

- All outputs are registered.
- Reset values: `vm_rst`=1; every other output is 0.
- `vm_rst` falls at the first rising edge after `rst` deasserts.
- States: IDLE, OWN0, OWN1, ABORT.
- **Eligibility:** requester k is eligible at an edge if `reqk`=1 and `gntk`=0. The current `gntk`=0 condition prevents double-accepting a held request.
- **IDLE:**
  - If exactly one requester is eligible, it is served.
  - If both are eligible, the round-robin pointer `rr` picks the winner. `rr` resets to 0.
  - Serving a legal coin (01/10): pulse `gntk`, drive `vm_in`=coin for one cycle, set credit = coin, clear the timer, go to OWNk.
  - Serving 00/11: pulse `gntk` only. `vm_in` stays 00 and the state stays IDLE.
- **OWNk:**
  - Only requester k is eligible. The other requester's `req` waits with no grant.
  - Each legal coin accepted: `gntk`, forward on `vm_in`, credit += coin (saturating at 7), timer cleared.
  - Illegal or 00 coin: granted and discarded. The timer is not cleared.
  - `vm_out`=1: pulse `vendk`, `chgk`=`vm_change`, credit=0, `rr`=other requester, go to IDLE. No coin is accepted at that edge.
  - Otherwise the timer increments each cycle. When timer==TIMEOUT, go to ABORT.
- **ABORT (1 cycle):** `vm_rst`=1, `refundk`=1, `refund_amt`=credit, credit=0, `rr`=other requester, go to IDLE.
- **Priority at an OWNk edge:** vend > timeout > coin acceptance.
- Reset mid-transaction: the transaction is dropped silently with no refund pulse. The core is held in reset via `vm_rst`.

## Timing

- Coin sampled at edge E: `gntk` and `vm_in` are valid in cycle E+1, and `vm_in` returns to 00 at E+2.
- `vm_out` sampled at edge E: `vendk` and `chgk` are valid in cycle E+1.
- Maximum acceptance rate is one coin per 2 cycles per requester, because a requester drops or changes `req` in the `gnt` cycle.
- Timeout: ABORT is entered TIMEOUT+1 edges after the last legal acceptance. `refundk` and `vm_rst` are high for exactly 1 cycle.
- `busy`=1 from the cycle after the first legal coin through the `vend`/`refund` cycle inclusive.

## Configuration

- `VEND_ARB_TIMEOUT_EN` defined: the timeout counter, ABORT state, `refund0`/`refund1`/`refund_amt` and abort-driven `vm_rst` are present as described above.
- `VEND_ARB_TIMEOUT_EN` undefined:
  - No timer or ABORT state; the lock is held until `vm_out`.
  - `refund*` and `refund_amt` are tied 0.
  - `vm_rst` is driven only by reset release.
  - `TIMEOUT` and `TW` are unused.

## Test plan

- **Reset:** `rst`=0 mid-OWN0 with credit 2. Require all outputs 0 except `vm_rst`=1; after release, `vm_rst`=0 at the first edge and state is IDLE.
- **Single transaction:** `req0` coin 10, then coin 01, with the core asserting `vm_out`, `change`=01. Require two `gnt0` pulses, `vm_in` 10 then 01 (one cycle each), `vend0`=1 and `chg0`=01 one cycle after `vm_out`, then `busy`=0.
- **Contention:** `req0` and `req1` both with coin 01 from IDLE after reset. Require `gnt0` first and `req1` blocked until `vend0`. Repeat with both requesting: `gnt1` wins (`rr` toggled).
- **Timeout:** `req1` coin 10, then idle, `TIMEOUT`=15. Require `refund1`=1, `refund_amt`=010 and `vm_rst`=1 in the same single cycle, 16 edges after acceptance; the next `req0` is then granted.
- **Illegal coin:** `req0` coin 11 in IDLE. Require a `gnt0` pulse, `vm_in`=00, `busy`=0. Same coin in OWN0: credit unchanged and timer not cleared.
- **Collision:** `vm_out`=1 on the same edge the timer reaches TIMEOUT and `req0` is pending. Require `vend0`, no `refund0`, and no `gnt0` at that edge.
